ext_alu_arbiter: RTL and testbench

EXT_ALU_ARBITER -- requirements
Module: ext_alu_arbiter

---
 rtl/ext_alu_arbiter.sv | 176 +++++++++++++++++
 tb/tb_ext_alu_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_alu_arbiter.sv
// Two-port round-robin front end for a shared extended ALU: grants one request,
// sequences it through a single execute cycle, and holds the response until accepted.
module ext_alu_arbiter (
  input  logic        clk,
  input  logic        rst,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_func,
  input  logic [31:0] req0_src1,
  input  logic [31:0] req0_src0,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_func,
  input  logic [31:0] req1_src1,
  input  logic [31:0] req1_src0,

  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        rsp_ov,
  output logic        rsp_zr,
  output logic        rsp_neg,
  output logic        rsp_err,

  output logic [31:0] alu_src1,
  output logic [31:0] alu_src0,
  output logic [2:0]  alu_func,
  input  logic [31:0] alu_dst,
  input  logic        alu_ov,
  input  logic        alu_zr,
  input  logic        alu_neg,

  output logic        busy,
  output logic [15:0] op_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] FUNC_UNDEF = 3'b111;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        id_q, id_d;
  logic [2:0]  func_q, func_d;
  logic [31:0] src1_q, src1_d;
  logic [31:0] src0_q, src0_d;
  logic        ov_q, ov_d;
  logic        zr_q, zr_d;
  logic        neg_q, neg_d;
  logic        err_q, err_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] op_cnt_q, op_cnt_d;
  logic        grant0, grant1;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    id_d        = id_q;
    func_d      = func_q;
    src1_d      = src1_q;
    src0_d      = src0_q;
    ov_d        = ov_q;
    zr_d        = zr_q;
    neg_d       = neg_q;
    err_d       = err_q;
    rsp_valid_d = rsp_valid_q;
    op_cnt_d    = op_cnt_q;
    grant0      = 1'b0;
    grant1      = 1'b0;

    case (state_q)
      IDLE: begin
        // last_q names the port granted most recently; the other one wins a tie
        if (req0_valid && (!req1_valid || last_q)) begin
          grant0 = 1'b1;
        end else if (req1_valid) begin
          grant1 = 1'b1;
        end
        if (grant0 || grant1) begin
          id_d   = grant1;
          last_d = grant1;
          func_d = grant1 ? req1_func : req0_func;
          src1_d = grant1 ? req1_src1 : req0_src1;
          src0_d = grant1 ? req1_src0 : req0_src0;
          ov_d   = 1'b0;
          zr_d   = 1'b0;
          neg_d  = 1'b0;
          if (func_d == FUNC_UNDEF) begin
            err_d       = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
          end else begin
            err_d   = 1'b0;
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        ov_d        = alu_ov;
        zr_d        = alu_zr;
        neg_d       = alu_neg;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
          if (op_cnt_q != 16'hFFFF) begin
            op_cnt_d = op_cnt_q + 16'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      id_q        <= 1'b0;
      func_q      <= '0;
      src1_q      <= '0;
      src0_q      <= '0;
      ov_q        <= 1'b0;
      zr_q        <= 1'b0;
      neg_q       <= 1'b0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      op_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      id_q        <= id_d;
      func_q      <= func_d;
      src1_q      <= src1_d;
      src0_q      <= src0_d;
      ov_q        <= ov_d;
      zr_q        <= zr_d;
      neg_q       <= neg_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      op_cnt_q    <= op_cnt_d;
    end
  end

  // Reset suppresses the combinational grant so no handshake completes in a reset cycle
  assign req0_ready = grant0 & ~rst;
  assign req1_ready = grant1 & ~rst;

  assign alu_src1  = src1_q;
  assign alu_src0  = src0_q;
  assign alu_func  = func_q;

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_data  = err_q ? '0 : alu_dst;
  assign rsp_ov    = ov_q;
  assign rsp_zr    = zr_q;
  assign rsp_neg   = neg_q;
  assign rsp_err   = err_q;

  assign busy   = (state_q != IDLE);
  assign op_cnt = op_cnt_q;

endmodule

// File: tb/tb_ext_alu_arbiter.sv
// Scoreboard bench for ext_alu_arbiter: directed ops push expected responses,
// a negedge monitor checks every presented response, busy/ready and op_cnt.
module tb_ext_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready;
  logic [2:0]  req0_func;
  logic [31:0] req0_src1, req0_src0;
  logic        req1_valid, req1_ready;
  logic [2:0]  req1_func;
  logic [31:0] req1_src1, req1_src0;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_data;
  logic        rsp_ov, rsp_zr, rsp_neg, rsp_err;
  logic [31:0] alu_src1, alu_src0, alu_dst;
  logic [2:0]  alu_func;
  logic        alu_ov, alu_zr, alu_neg;
  logic        busy;
  logic [15:0] op_cnt;

  ext_alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_func(req0_func),
    .req0_src1(req0_src1), .req0_src0(req0_src0),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_func(req1_func),
    .req1_src1(req1_src1), .req1_src0(req1_src0),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_ov(rsp_ov), .rsp_zr(rsp_zr), .rsp_neg(rsp_neg), .rsp_err(rsp_err),
    .alu_src1(alu_src1), .alu_src0(alu_src0), .alu_func(alu_func), .alu_dst(alu_dst),
    .alu_ov(alu_ov), .alu_zr(alu_zr), .alu_neg(alu_neg),
    .busy(busy), .op_cnt(op_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural extended ALU: result registered one clock after operands, flags combinational
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] b;
    logic [10:0] e;
    if (f[30:0] == 31'd0) return 0.0;
    e = {3'b000, f[30:23]} + 11'd896;
    b = {f[31], e, f[22:0], 29'd0};
    return $bitstoreal(b);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] b;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    b = $realtobits(r);
    e = b[62:52] - 11'd896;
    return {b[63], e[7:0], b[51:29]};
  endfunction

  logic [31:0] alu_res;
  logic        alu_ov_m;
  always_comb begin
    logic signed [63:0] sp;
    logic [63:0] up;
    sp = '0;
    up = '0;
    alu_res = '0;
    alu_ov_m = 1'b0;
    case (alu_func)
      3'd0: begin
        sp = $signed({{32{alu_src1[31]}}, alu_src1}) * $signed({{32{alu_src0[31]}}, alu_src0});
        alu_res = sp[31:0];
        alu_ov_m = !((sp[63:31] == '0) || (sp[63:31] == '1));
      end
      3'd1: begin
        up = {32'd0, alu_src1} * {32'd0, alu_src0};
        alu_res = up[31:0];
        alu_ov_m = |up[63:32];
      end
      3'd2: alu_res = r2f(f2r(alu_src1) + f2r(alu_src0));
      3'd3: alu_res = r2f(f2r(alu_src1) - f2r(alu_src0));
      3'd4: alu_res = r2f(f2r(alu_src1) * f2r(alu_src0));
      3'd5: alu_res = r2f($itor($signed(alu_src1)));
      3'd6: alu_res = 32'($rtoi(f2r(alu_src1)));
      default: alu_res = '0;
    endcase
  end
  always @(posedge clk) alu_dst <= alu_res;
  assign alu_ov  = alu_ov_m;
  assign alu_zr  = (alu_res == 32'd0);
  assign alu_neg = alu_res[31];

  typedef struct {
    logic        id;
    logic [31:0] data;
    logic        ov, zr, neg, err;
    int          lat;
    longint      issue;
  } exp_t;

  exp_t   sb[$];
  int     grant_log[$];
  int     n_cmp = 0;
  int     n_err = 0;
  longint cyc = 0;
  bit     mon_en = 1'b0;
  bit     inflight = 1'b0;
  bit     seen = 1'b0;
  logic [15:0] mdl_cnt = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      n_cmp++;
      if (busy !== inflight) begin
        n_err++;
        $display("FAIL busy got %0b want %0b at cycle %0d", busy, inflight, cyc);
      end
      if (inflight) begin
        n_cmp++;
        if (req0_ready || req1_ready) begin
          n_err++;
          $display("FAIL ready_while_busy got %0b%0b want 00 at cycle %0d", req1_ready, req0_ready, cyc);
        end
      end
      n_cmp++;
      if (op_cnt !== mdl_cnt) begin
        n_err++;
        $display("FAIL op_cnt got %h want %h at cycle %0d", op_cnt, mdl_cnt, cyc);
      end
      if (rsp_valid) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_rsp got id=%0b data=%h want no response at cycle %0d", rsp_id, rsp_data, cyc);
        end else begin
          e = sb[0];
          if (rsp_id !== e.id || rsp_data !== e.data || rsp_ov !== e.ov || rsp_zr !== e.zr ||
              rsp_neg !== e.neg || rsp_err !== e.err) begin
            n_err++;
            $display("FAIL rsp_fields got id=%0b data=%h ov=%0b zr=%0b neg=%0b err=%0b want id=%0b data=%h ov=%0b zr=%0b neg=%0b err=%0b",
                     rsp_id, rsp_data, rsp_ov, rsp_zr, rsp_neg, rsp_err,
                     e.id, e.data, e.ov, e.zr, e.neg, e.err);
          end
          if (!seen) begin
            n_cmp++;
            if (cyc - e.issue != longint'(e.lat)) begin
              n_err++;
              $display("FAIL latency got %0d want %0d", cyc - e.issue, e.lat);
            end
            seen = 1'b1;
          end
          if (rsp_ready) begin
            void'(sb.pop_front());
            seen = 1'b0;
            inflight = 1'b0;
            if (mdl_cnt != 16'hFFFF) mdl_cnt = mdl_cnt + 16'd1;
          end
        end
      end
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) inflight = 1'b1;
      if (rst) begin
        inflight = 1'b0;
        seen = 1'b0;
        mdl_cnt = '0;
        sb.delete();
      end
    end
  end

  task automatic set_port(input int p, input logic v, input logic [2:0] f,
                          input logic [31:0] s1, input logic [31:0] s0);
    if (p == 0) begin
      req0_valid = v; req0_func = f; req0_src1 = s1; req0_src0 = s0;
    end else begin
      req1_valid = v; req1_func = f; req1_src1 = s1; req1_src0 = s0;
    end
  endtask

  task automatic drive(input int p, input logic [2:0] f, input logic [31:0] s1, input logic [31:0] s0,
                       input logic [31:0] d, input logic ov, input logic zr, input logic neg,
                       input logic err, input bit push);
    exp_t e;
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    set_port(p, 1'b1, f, s1, s0);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if ((p == 0) ? req0_ready : req1_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL grant_timeout port %0d got no ready want ready", p);
    end else begin
      grant_log.push_back(p);
      if (push) begin
        e.id = (p == 1); e.data = d; e.ov = ov; e.zr = zr; e.neg = neg; e.err = err;
        e.lat = err ? 1 : 2;
        e.issue = cyc;
        sb.push_back(e);
      end
    end
    @(posedge clk); #1;
    set_port(p, 1'b0, f, s1, s0);
  endtask

  task automatic wait_drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #2;
      if (sb.size() == 0 && !inflight) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_%s got %0d pending want 0", name, sb.size());
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int gexp[4];
    bit ok;
    gexp = '{0, 1, 0, 1};
    rst = 1'b1;
    rsp_ready = 1'b1;
    set_port(0, 1'b0, 3'd0, '0, '0);
    set_port(1, 1'b0, 3'd0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    req0_valid = 1'b1;
    @(negedge clk);
    chk("ready_in_reset", {31'd0, req0_ready}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_op_cnt", {16'd0, op_cnt}, 32'd0);
    chk("reset_alu_src1", alu_src1, 32'd0);
    chk("reset_alu_src0", alu_src0, 32'd0);
    chk("reset_alu_func", {29'd0, alu_func}, 32'd0);
    chk("reset_err_flags", {28'd0, rsp_err, rsp_ov, rsp_zr, rsp_neg}, 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    rst = 1'b0;
    mon_en = 1'b1;

    // Contention from reset: grants must alternate starting at port 0
    grant_log.delete();
    fork
      begin
        drive(0, 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        drive(0, 3'd0, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      end
      begin
        drive(1, 3'd1, 32'd100, 32'd200, 32'h00004E20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1, 3'd2, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      end
    join
    wait_drain("contention");
    chk("contention_grants", grant_log.size(), 32'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) chk("contention_order", grant_log[i], gexp[i]);
    chk("contention_op_cnt", {16'd0, op_cnt}, 32'd4);

    // Single MULF 2.0 * 3.0
    drive(0, 3'd4, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_drain("single");

    // Backpressure: SUBF 3.0-3.0 held five cycles; a short req0 pulse must not be granted
    rsp_ready = 1'b0;
    fork
      drive(1, 3'd3, 32'h40400000, 32'h40400000, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      begin
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (rsp_valid) begin
            ok = 1'b1;
            break;
          end
        end
        n_cmp++;
        if (!ok) begin
          n_err++;
          $display("FAIL bp_rsp_timeout got no rsp_valid want rsp_valid");
        end
        @(posedge clk); #1;
        set_port(0, 1'b1, 3'd2, 32'h3F800000, 32'h3F800000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        set_port(0, 1'b0, 3'd0, '0, '0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rsp_ready = 1'b1;
      end
    join
    wait_drain("backpressure");
    repeat (3) @(negedge clk);
    drive(0, 3'd2, 32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_drain("after_bp");

    // Undefined func then UMUL 0xFFFF * 2
    drive(1, 3'd7, 32'h12345678, 32'h00000009, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(1, 3'd1, 32'h0000FFFF, 32'h00000002, 32'h0001FFFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_drain("undefined");

    // Reset while a port-1 MUL is in EXEC
    drive(1, 3'd0, 32'd5, 32'd5, 32'd25, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_mid_op_cnt", {16'd0, op_cnt}, 32'd0);
    grant_log.delete();
    fork
      drive(0, 3'd0, 32'd2, 32'd3, 32'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      drive(1, 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    join
    wait_drain("rst_mid");
    chk("rst_mid_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 32'd0);

    // Saturation of op_cnt from 0xFFFE
    @(negedge clk); #1;
    force dut.op_cnt_q = 16'hFFFE;
    mdl_cnt = 16'hFFFE;
    @(negedge clk); #1;
    release dut.op_cnt_q;
    drive(0, 3'd5, 32'd5, 32'd0, 32'h40A00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(0, 3'd6, 32'h40E00000, 32'd0, 32'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(0, 3'd0, 32'd0, 32'd9, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_drain("saturation");
    chk("sat_op_cnt", {16'd0, op_cnt}, 32'h0000FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
